// File: rtl/axis_len_framer.sv
// Frames an AXI-Stream packet by the big-endian length field in its first beat:
// trims surplus beats, flags short/long/bad packets and sets tkeep on the last beat.
module axis_len_framer #(
  parameter int DATA_WIDTH = 512,
  parameter int LEN_OFFSET = 16,
  parameter int MAX_LEN    = 9600,
  localparam int BEAT_BYTES = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [BEAT_BYTES-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           err_short_cnt,
  output logic [15:0]           err_long_cnt,
  output logic [15:0]           err_len_cnt
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t                state_q, state_d;
  logic                  en_q;
  logic [15:0]           cnt_q, cnt_d;
  logic [16:0]           exp_q, exp_d;
  logic [BEAT_BYTES-1:0] lkeep_q, lkeep_d;
  logic                  bad_q, bad_d;

  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [BEAT_BYTES-1:0] tkeep_q, tkeep_d;
  logic                  tlast_q, tlast_d;
  logic                  tvalid_q, tvalid_d;

  logic [15:0] pkt_q, short_q, long_q, len_q;
  logic        inc_short, inc_long, inc_len;

  logic [15:0]           len_w, len_rem;
  logic [16:0]           len_exp;
  logic                  len_bad;
  logic [BEAT_BYTES-1:0] len_mask;

  logic [16:0]           cur_exp, n_beat;
  logic [BEAT_BYTES-1:0] cur_keep;
  logic                  cur_bad;
  logic                  in_hs, out_hs;

  // Length decode only matters on the beat-0 handshake; it is latched for the rest.
  always_comb begin
    len_w    = {s_axis_tdata[8*LEN_OFFSET +: 8], s_axis_tdata[8*(LEN_OFFSET+1) +: 8]};
    len_exp  = ({1'b0, len_w} + 17'(BEAT_BYTES - 1)) / 17'(BEAT_BYTES);
    len_rem  = len_w % 16'(BEAT_BYTES);
    len_bad  = (len_w == 16'd0) || ({16'd0, len_w} > 32'(MAX_LEN));
    len_mask = '1;
    for (int i = 0; i < BEAT_BYTES; i++)
      len_mask[i] = (len_rem == 16'd0) || (16'(i) < len_rem);
  end

  assign s_axis_tready = en_q && ((state_q == DROP) || !tvalid_q || m_axis_tready);
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = tvalid_q && m_axis_tready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    lkeep_d   = lkeep_q;
    bad_d     = bad_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tlast_d   = tlast_q;
    tvalid_d  = tvalid_q && !m_axis_tready;
    inc_short = 1'b0;
    inc_long  = 1'b0;
    inc_len   = 1'b0;

    if (state_q == IDLE) begin
      cur_exp  = len_exp;
      cur_keep = len_mask;
      cur_bad  = len_bad;
      n_beat   = 17'd1;
    end else begin
      cur_exp  = exp_q;
      cur_keep = lkeep_q;
      cur_bad  = bad_q;
      n_beat   = {1'b0, cnt_q} + 17'd1;
    end

    if (in_hs) begin
      if (state_q == DROP) begin
        if (s_axis_tlast) state_d = IDLE;
      end else begin
        tvalid_d = 1'b1;
        tdata_d  = s_axis_tdata;
        tkeep_d  = '1;
        tlast_d  = 1'b0;
        cnt_d    = n_beat[15:0];
        if (state_q == IDLE) begin
          exp_d   = len_exp;
          lkeep_d = len_mask;
          bad_d   = len_bad;
          inc_len = len_bad;
        end
        if (cur_bad) begin
          tlast_d = s_axis_tlast;
          state_d = s_axis_tlast ? IDLE : PASS;
        end else if (n_beat == cur_exp) begin
          tlast_d = 1'b1;
          tkeep_d = cur_keep;
          if (s_axis_tlast) begin
            state_d = IDLE;
          end else begin
            inc_long = 1'b1;
            state_d  = DROP;
          end
        end else if (s_axis_tlast) begin
          // Packet ended before its advertised length.
          tlast_d   = 1'b1;
          inc_short = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = PASS;
        end
      end
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      cnt_q    <= '0;
      exp_q    <= '0;
      lkeep_q  <= '0;
      bad_q    <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      pkt_q    <= '0;
      short_q  <= '0;
      long_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= 1'b1;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      lkeep_q  <= lkeep_d;
      bad_q    <= bad_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      pkt_q    <= sat_inc(pkt_q, out_hs && tlast_q);
      short_q  <= sat_inc(short_q, inc_short);
      long_q   <= sat_inc(long_q, inc_long);
      len_q    <= sat_inc(len_q, inc_len);
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign pkt_cnt       = pkt_q;
  assign err_short_cnt = short_q;
  assign err_long_cnt  = long_q;
  assign err_len_cnt   = len_q;

endmodule
